imem_responder: RTL and testbench

//  Instruction-memory responder: the memory end of the fetch interface that the IFU drives with its pc.

---
 rtl/imem_responder.sv | 128 ++++++++++++
 tb/tb_imem_responder.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_responder.sv
// Instruction-memory responder: accepts one fetch at a time, waits LATENCY cycles, returns the word.
// Optional address-fault checking is enabled with the IMEM_CHECK_EN macro.
module imem_responder #(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_3000,
  parameter int          DEPTH_WORDS = 4096,
  parameter int          LATENCY     = 2
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           req_valid,
  output logic                           req_ready,
  input  logic [31:0]                    req_addr,
  output logic                           rsp_valid,
  input  logic                           rsp_ready,
  output logic [31:0]                    rsp_instr,
  output logic [31:0]                    rsp_pc,
  output logic                           rsp_err,
  input  logic                           load_we,
  input  logic [$clog2(DEPTH_WORDS)-1:0] load_idx,
  input  logic [31:0]                    load_data,
  output logic                           busy,
  output logic [1:0]                     dbg_state
);
  localparam int IDX_W = $clog2(DEPTH_WORDS);

  // Handshake: a request transfers on a rising edge with req_valid && req_ready,
  // a response transfers on a rising edge with rsp_valid && rsp_ready; once raised,
  // rsp_valid and its payload stay stable until that transfer happens.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [3:0]        r_cnt;
  logic [31:0]       r_addr;
  logic [31:0]       r_instr;
  logic [31:0]       r_pc;
  logic [31:0]       r_mem [DEPTH_WORDS];
  logic              w_accept;
  logic              w_capture;
  logic [31:0]       w_cap_addr;
  logic [31:0]       w_off;
  logic [IDX_W-1:0]  w_idx;
  logic              w_fault;

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_capture   = 1'b0;
    case (r_state)
      IDLE: begin
        if (req_valid) begin
          w_accept    = 1'b1;
          w_capture   = (LATENCY == 1);
          w_state_nxt = (LATENCY == 1) ? RESP : WAIT;
        end
      end
      WAIT: begin
        if (r_cnt == 4'd1) begin
          w_capture   = 1'b1;
          w_state_nxt = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // With LATENCY==1 the capture happens on the accept edge, so read straight from the request.
  assign w_cap_addr = (r_state == IDLE) ? req_addr : r_addr;
  assign w_off      = w_cap_addr - BASE_ADDR;
  assign w_idx      = IDX_W'(w_off >> 2);

`ifdef IMEM_CHECK_EN
  logic r_err;
  assign w_fault = (w_cap_addr < BASE_ADDR)
                || ({1'b0, w_cap_addr} >= (33'(BASE_ADDR) + 33'(4 * DEPTH_WORDS)))
                || (w_cap_addr[1:0] != 2'b00);

  always_ff @(posedge clk) begin
    if (reset)          r_err <= 1'b0;
    else if (w_capture) r_err <= w_fault;
  end
  assign rsp_err = r_err;
`else
  assign w_fault = 1'b0;
  assign rsp_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_cnt   <= 4'd0;
      r_addr  <= 32'd0;
      r_instr <= 32'd0;
      r_pc    <= 32'd0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_addr <= req_addr;
        r_cnt  <= 4'(LATENCY - 1);
      end else if (r_state == WAIT) begin
        r_cnt <= r_cnt - 4'd1;
      end
      if (w_capture) begin
        r_instr <= w_fault ? 32'd0 : r_mem[w_idx];
        r_pc    <= w_cap_addr;
      end
    end
  end

  // Load writes are not reset and land after any same-edge read (old word is returned).
  always_ff @(posedge clk) begin
    if (load_we) r_mem[load_idx] <= load_data;
  end

  assign req_ready = (r_state == IDLE);
  assign rsp_valid = (r_state == RESP);
  assign busy      = (r_state != IDLE);
  assign rsp_instr = r_instr;
  assign rsp_pc    = r_pc;
  assign dbg_state = r_state;
endmodule

// File: tb/tb_imem_responder.sv
// Directed bench for imem_responder: a LATENCY=2 instance for most scenarios, a LATENCY=1 instance for throughput.
module tb_imem_responder;
  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, rsp_ready, load_we;
  logic [31:0] req_addr, load_data;
  logic [11:0] load_idx;
  logic        req_ready, rsp_valid, rsp_err, busy;
  logic [31:0] rsp_instr, rsp_pc;
  logic [1:0]  dbg_state;

  logic        req_valid1, rsp_ready1, load_we1;
  logic [31:0] req_addr1, load_data1;
  logic [11:0] load_idx1;
  logic        req_ready1, rsp_valid1, rsp_err1, busy1;
  logic [31:0] rsp_instr1, rsp_pc1;
  logic [1:0]  dbg_state1;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  imem_responder #(.LATENCY(2)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_instr(rsp_instr), .rsp_pc(rsp_pc), .rsp_err(rsp_err),
    .load_we(load_we), .load_idx(load_idx), .load_data(load_data),
    .busy(busy), .dbg_state(dbg_state)
  );

  imem_responder #(.LATENCY(1)) dut1 (
    .clk(clk), .reset(reset), .req_valid(req_valid1), .req_ready(req_ready1),
    .req_addr(req_addr1), .rsp_valid(rsp_valid1), .rsp_ready(rsp_ready1),
    .rsp_instr(rsp_instr1), .rsp_pc(rsp_pc1), .rsp_err(rsp_err1),
    .load_we(load_we1), .load_idx(load_idx1), .load_data(load_data1),
    .busy(busy1), .dbg_state(dbg_state1)
  );

  // All tasks start and end just after a falling edge.
  task automatic load0(input logic [11:0] idx, input logic [31:0] data);
    load_we = 1'b1; load_idx = idx; load_data = data;
    @(negedge clk);
    load_we = 1'b0;
  endtask

  task automatic load1(input logic [11:0] idx, input logic [31:0] data);
    load_we1 = 1'b1; load_idx1 = idx; load_data1 = data;
    @(negedge clk);
    load_we1 = 1'b0;
  endtask

  task automatic fetch0(input logic [31:0] addr, output int lat,
                        output logic [31:0] instr, output logic [31:0] pc, output logic err);
    req_valid = 1'b1; req_addr = addr; rsp_ready = 1'b0;
    lat = 0;
    do begin
      @(negedge clk);
      req_valid = 1'b0;
      lat++;
    end while (!rsp_valid && lat < 20);
    instr = rsp_instr; pc = rsp_pc; err = rsp_err;
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    n_tests++;
    if ({rsp_valid, req_ready, busy, rsp_err} !== 4'b0100 || rsp_instr !== 32'd0 || rsp_pc !== 32'd0) begin
      n_fail++;
      $display("FAIL reset: valid/ready/busy/err=%b instr=%h pc=%h, want 0100 0 0",
               {rsp_valid, req_ready, busy, rsp_err}, rsp_instr, rsp_pc);
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic_fetch();
    int lat; logic [31:0] instr, pc; logic err;
    fetch0(32'h3000, lat, instr, pc, err);
    n_tests++;
    if (lat !== 2 || instr !== 32'h3c010001 || pc !== 32'h3000 || err !== 1'b0) begin
      n_fail++;
      $display("FAIL fetch_3000: lat=%0d instr=%h pc=%h err=%b, want 2 3c010001 3000 0", lat, instr, pc, err);
    end
    fetch0(32'h3004, lat, instr, pc, err);
    n_tests++;
    if (lat !== 2 || instr !== 32'h34210002 || pc !== 32'h3004 || err !== 1'b0) begin
      n_fail++;
      $display("FAIL fetch_3004: lat=%0d instr=%h pc=%h err=%b, want 2 34210002 3004 0", lat, instr, pc, err);
    end
  endtask

  task automatic test_backpressure();
    int lat;
    req_valid = 1'b1; req_addr = 32'h3004; rsp_ready = 1'b0;
    lat = 0;
    do begin
      @(negedge clk);
      req_valid = 1'b0;
      lat++;
    end while (!rsp_valid && lat < 20);
    n_tests++;
    if (dbg_state !== 2'd2) begin
      n_fail++;
      $display("FAIL state_resp: state=%0d, want 2", dbg_state);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_tests++;
      if (rsp_valid !== 1'b1 || req_ready !== 1'b0 || busy !== 1'b1 ||
          rsp_instr !== 32'h34210002 || rsp_pc !== 32'h3004) begin
        n_fail++;
        $display("FAIL hold_%0d: valid=%b ready=%b busy=%b instr=%h pc=%h, want 1 0 1 34210002 3004",
                 i, rsp_valid, req_ready, busy, rsp_instr, rsp_pc);
      end
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    n_tests++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL release: valid=%b ready=%b busy=%b, want 0 1 0", rsp_valid, req_ready, busy);
    end
  endtask

  task automatic test_address_range();
    logic [31:0] addrs [3];
    logic [31:0] exp_instr [3];
    int lat; logic [31:0] instr, pc; logic err, exp_err;
    addrs[0] = 32'h7000; addrs[1] = 32'h3002; addrs[2] = 32'h2ffc;
`ifdef IMEM_CHECK_EN
    exp_instr[0] = 32'd0; exp_instr[1] = 32'd0; exp_instr[2] = 32'd0;
    exp_err = 1'b1;
`else
    exp_instr[0] = 32'h3c010001; exp_instr[1] = 32'h3c010001; exp_instr[2] = 32'h0badf00d;
    exp_err = 1'b0;
`endif
    for (int i = 0; i < 3; i++) begin
      fetch0(addrs[i], lat, instr, pc, err);
      n_tests++;
      if (lat !== 2 || instr !== exp_instr[i] || pc !== addrs[i] || err !== exp_err) begin
        n_fail++;
        $display("FAIL range_%h: lat=%0d instr=%h pc=%h err=%b, want 2 %h %h %b",
                 addrs[i], lat, instr, pc, err, exp_instr[i], addrs[i], exp_err);
      end
    end
  endtask

  task automatic test_reset_in_wait();
    int lat; logic [31:0] instr, pc; logic err;
    logic seen_valid;
    req_valid = 1'b1; req_addr = 32'h3000; rsp_ready = 1'b0;
    @(negedge clk);
    req_valid = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    n_tests++;
    if (req_ready !== 1'b1 || busy !== 1'b0 || rsp_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL abort: ready=%b busy=%b valid=%b, want 1 0 0", req_ready, busy, rsp_valid);
    end
    reset = 1'b0;
    seen_valid = 1'b0;
    repeat (4) begin
      @(negedge clk);
      seen_valid = seen_valid | rsp_valid;
    end
    n_tests++;
    if (seen_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_no_rsp: rsp_valid seen=%b, want 0", seen_valid);
    end
    fetch0(32'h3000, lat, instr, pc, err);
    n_tests++;
    if (lat !== 2 || instr !== 32'h3c010001) begin
      n_fail++;
      $display("FAIL mem_kept: lat=%0d instr=%h, want 2 3c010001", lat, instr);
    end
  endtask

  task automatic test_read_before_write();
    int lat; logic [31:0] instr, pc; logic err;
    req_valid = 1'b1; req_addr = 32'h3004; rsp_ready = 1'b0;
    @(negedge clk);
    req_valid = 1'b0;
    load_we = 1'b1; load_idx = 12'd1; load_data = 32'hdeadbeef;
    @(negedge clk);
    load_we = 1'b0;
    n_tests++;
    if (rsp_valid !== 1'b1 || rsp_instr !== 32'h34210002) begin
      n_fail++;
      $display("FAIL rbw_old: valid=%b instr=%h, want 1 34210002", rsp_valid, rsp_instr);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    fetch0(32'h3004, lat, instr, pc, err);
    n_tests++;
    if (lat !== 2 || instr !== 32'hdeadbeef) begin
      n_fail++;
      $display("FAIL rbw_new: lat=%0d instr=%h, want 2 deadbeef", lat, instr);
    end
  endtask

  task automatic test_back_to_back();
    int accepts;
    logic [3:0] ready_trace, valid_trace;
    load1(12'd0, 32'h11112222);
    req_valid1 = 1'b1; req_addr1 = 32'h3000; rsp_ready1 = 1'b1;
    accepts = 0;
    for (int i = 0; i < 8; i++) begin
      if (i < 4) ready_trace[3 - i] = req_ready1;
      if (req_ready1 && req_valid1) accepts++;
      @(negedge clk);
      if (i < 4) valid_trace[3 - i] = rsp_valid1;
      if (i == 0) begin
        n_tests++;
        if (rsp_valid1 !== 1'b1 || rsp_instr1 !== 32'h11112222 || rsp_pc1 !== 32'h3000) begin
          n_fail++;
          $display("FAIL lat1_first: valid=%b instr=%h pc=%h, want 1 11112222 3000",
                   rsp_valid1, rsp_instr1, rsp_pc1);
        end
      end
    end
    req_valid1 = 1'b0; rsp_ready1 = 1'b0;
    n_tests++;
    if (accepts !== 4 || ready_trace !== 4'b1010 || valid_trace !== 4'b1010) begin
      n_fail++;
      $display("FAIL lat1_rate: accepts=%0d ready=%b valid=%b, want 4 1010 1010",
               accepts, ready_trace, valid_trace);
    end
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1;
    req_valid = 1'b0; rsp_ready = 1'b0; load_we = 1'b0;
    req_addr = 32'd0; load_idx = 12'd0; load_data = 32'd0;
    req_valid1 = 1'b0; rsp_ready1 = 1'b0; load_we1 = 1'b0;
    req_addr1 = 32'd0; load_idx1 = 12'd0; load_data1 = 32'd0;
    @(negedge clk);
    test_reset();
    load0(12'd0, 32'h3c010001);
    load0(12'd1, 32'h34210002);
    load0(12'd4095, 32'h0badf00d);
    test_basic_fetch();
    test_backpressure();
    test_address_range();
    test_reset_in_wait();
    test_read_before_write();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded 100000 time units");
    $fatal(1, "timeout");
  end
endmodule
